// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with a one-deep load buffer.
// The buffer is swapped into the display only at frame boundaries, and each digit slot starts with a dead-time gap.
module seg7_scan_driver #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYC    = 16,
    parameter bit EN_ACT_LOW  = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] DATA,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    input  logic        BLANK_LZ,
    output logic        FRAME_DONE,
    output logic        DS_EN1,
    output logic        DS_EN2,
    output logic        DS_EN3,
    output logic        DS_EN4,
    output logic        DS_A,
    output logic        DS_B,
    output logic        DS_C,
    output logic        DS_D,
    output logic        DS_E,
    output logic        DS_F,
    output logic        DS_G
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pcnt;
    logic [1:0]    digitIdx;
    logic [15:0]   dispReg;
    logic [15:0]   pendReg;
    logic          pendFull;
    logic          frameDone;
    logic [3:0]    enPins;
    logic [6:0]    segPins;

    logic          lastTick;
    logic          boundary;
    logic          accept;
    logic [3:0]    shamt;
    logic [3:0]    curNibble;
    logic [3:0]    leadZero;
    logic          blankNow;
    logic          showNow;
    logic [3:0]    enNext;
    logic [6:0]    segNext;

    function automatic logic [6:0] hexToSeg(input logic [3:0] n);
        case (n)
            4'h0:    hexToSeg = 7'h3F;
            4'h1:    hexToSeg = 7'h06;
            4'h2:    hexToSeg = 7'h5B;
            4'h3:    hexToSeg = 7'h4F;
            4'h4:    hexToSeg = 7'h66;
            4'h5:    hexToSeg = 7'h6D;
            4'h6:    hexToSeg = 7'h7D;
            4'h7:    hexToSeg = 7'h07;
            4'h8:    hexToSeg = 7'h7F;
            4'h9:    hexToSeg = 7'h6F;
            4'hA:    hexToSeg = 7'h77;
            4'hB:    hexToSeg = 7'h7C;
            4'hC:    hexToSeg = 7'h39;
            4'hD:    hexToSeg = 7'h5E;
            4'hE:    hexToSeg = 7'h79;
            default: hexToSeg = 7'h71;
        endcase
    endfunction

    assign lastTick = (pcnt == PW'(SCAN_DIV - 1));
    assign boundary = lastTick && (digitIdx == 2'd3);
    assign accept   = DATA_VALID && !pendFull;

    // Digit 0 is the leftmost nibble [15:12], so the shift is (3 - digit) * 4.
    assign shamt     = {~digitIdx, 2'b00};
    assign curNibble = dispReg[shamt +: 4];

    // leadZero[d]: every nibble from the leftmost through digit d is zero.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gLead
            assign leadZero[gi] = (dispReg[15 -: 4*(gi+1)] == '0);
        end
    endgenerate
    assign leadZero[3] = 1'b0;

    assign blankNow = BLANK_LZ && leadZero[digitIdx];
    assign showNow  = (pcnt >= PW'(DEAD_CYC)) && !blankNow;
    assign enNext   = showNow ? (4'b0001 << digitIdx) : 4'b0000;
    assign segNext  = showNow ? hexToSeg(curNibble) : 7'h00;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt      <= '0;
            digitIdx  <= 2'd0;
            dispReg   <= 16'h0000;
            pendReg   <= 16'h0000;
            pendFull  <= 1'b0;
            frameDone <= 1'b0;
            enPins    <= {4{EN_ACT_LOW}};
            segPins   <= {7{SEG_ACT_LOW}};
        end else begin
            pcnt      <= lastTick ? '0 : pcnt + PW'(1);
            if (lastTick) begin
                digitIdx <= digitIdx + 2'd1;
            end
            enPins    <= enNext ^ {4{EN_ACT_LOW}};
            segPins   <= segNext ^ {7{SEG_ACT_LOW}};
            frameDone <= boundary && pendFull;
            // A full buffer blocks accept, so swap and load never collide.
            if (boundary && pendFull) begin
                dispReg  <= pendReg;
                pendFull <= 1'b0;
            end else if (accept) begin
                pendReg  <= DATA;
                pendFull <= 1'b1;
            end
        end
    end

    assign DATA_READY = !pendFull;
    assign FRAME_DONE = frameDone;

    assign DS_EN1 = enPins[0];
    assign DS_EN2 = enPins[1];
    assign DS_EN3 = enPins[2];
    assign DS_EN4 = enPins[3];

    assign DS_A = segPins[0];
    assign DS_B = segPins[1];
    assign DS_C = segPins[2];
    assign DS_D = segPins[3];
    assign DS_E = segPins[4];
    assign DS_F = segPins[5];
    assign DS_G = segPins[6];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=8, DEAD_CYC=2, active-high pins).
// A frame-level model steps once per clock and is compared on every falling edge.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] DATA = 16'h0000;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic        BLANK_LZ = 1'b0;
    logic        FRAME_DONE;
    logic        DS_EN1, DS_EN2, DS_EN3, DS_EN4;
    logic        DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G;

    seg7_scan_driver #(
        .SCAN_DIV(8), .DEAD_CYC(2), .EN_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .BLANK_LZ(BLANK_LZ), .FRAME_DONE(FRAME_DONE),
        .DS_EN1(DS_EN1), .DS_EN2(DS_EN2), .DS_EN3(DS_EN3), .DS_EN4(DS_EN4),
        .DS_A(DS_A), .DS_B(DS_B), .DS_C(DS_C), .DS_D(DS_D),
        .DS_E(DS_E), .DS_F(DS_F), .DS_G(DS_G)
    );

    always #5 CLK = ~CLK;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int failures = 0;

    // Model state: clocks since reset release, shown value, buffered value.
    int          cnt = 0;
    logic [15:0] mDisp = 16'h0000;
    logic [15:0] mPend = 16'h0000;
    bit          mFull = 1'b0;
    logic [3:0]  expEn = 4'h0;
    logic [6:0]  expSeg = 7'h00;
    bit          expFd = 1'b0;

    int          slot, phase;
    logic [15:0] upper;
    bit          blanked, fullOld;
    logic [3:0]  actEn;
    logic [6:0]  actSeg;

    always_comb begin
        actEn  = {DS_EN4, DS_EN3, DS_EN2, DS_EN1};
        actSeg = {DS_G, DS_F, DS_E, DS_D, DS_C, DS_B, DS_A};
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, cnt, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs that were present at the rising edge.
    task automatic modelStep();
        if (!RST_N) begin
            cnt = 0; mDisp = 16'h0000; mPend = 16'h0000; mFull = 1'b0;
            expEn = 4'h0; expSeg = 7'h00; expFd = 1'b0;
        end else begin
            phase   = cnt % 8;
            slot    = (cnt / 8) % 4;
            upper   = mDisp >> (12 - 4 * slot);
            blanked = BLANK_LZ && (slot < 3) && (upper == 16'h0000);
            if (phase >= 2 && !blanked) begin
                expEn  = 4'(1 << slot);
                expSeg = SEG_TAB[upper[3:0]];
            end else begin
                expEn  = 4'h0;
                expSeg = 7'h00;
            end
            fullOld = mFull;
            expFd   = 1'b0;
            if ((cnt % 32) == 31 && fullOld) begin
                mDisp = mPend; mFull = 1'b0; expFd = 1'b1;
            end
            if (DATA_VALID && !fullOld) begin
                mPend = DATA; mFull = 1'b1;
            end
            cnt++;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        modelStep();
        checkVal("en", {12'h0, actEn}, {12'h0, expEn});
        checkVal("seg", {9'h0, actSeg}, {9'h0, expSeg});
        checkVal("ready", {15'h0, DATA_READY}, {15'h0, !mFull});
        checkVal("frame_done", {15'h0, FRAME_DONE}, {15'h0, expFd});
        checkVal("onehot_en", {15'h0, $onehot0(actEn)}, 16'h0001);
    endtask

    task automatic toEdge(input int n);
        int guard = 0;
        while (cnt < n && guard < 4000) begin
            tick();
            guard++;
        end
        checkVal("reach_edge", 16'(cnt), 16'(n));
    endtask

    task automatic loadWord(input logic [15:0] v, input int e);
        toEdge(e - 1);
        DATA = v;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        $display("load %h at edge %0d ready_after=%0b", v, e, DATA_READY);
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkVal(name, act, exp);
    endtask

    initial begin
        // 1: idle scan of 0000 after reset
        RST_N = 1'b0;
        repeat (5) tick();
        RST_N = 1'b1;
        toEdge(1);  lit("t1_gap_en", {12'h0, actEn}, 16'h0000);
        toEdge(2);  lit("t1_gap2_en", {12'h0, actEn}, 16'h0000);
        toEdge(3);  lit("t1_en1", {12'h0, actEn}, 16'h0001);
                    lit("t1_seg", {9'h0, actSeg}, 16'h003F);
        toEdge(11); lit("t1_en2", {12'h0, actEn}, 16'h0002);
        toEdge(19); lit("t1_en3", {12'h0, actEn}, 16'h0004);
        toEdge(27); lit("t1_en4", {12'h0, actEn}, 16'h0008);
        toEdge(33); lit("t1_wrap_gap", {12'h0, actEn}, 16'h0000);
        toEdge(35); lit("t1_wrap_en1", {12'h0, actEn}, 16'h0001);

        // 2: load at start of frame 0, shown in frame 1
        RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        loadWord(16'h12AF, 1);
        lit("t2_ready_low", {15'h0, DATA_READY}, 16'h0000);
        toEdge(32); lit("t2_fd", {15'h0, FRAME_DONE}, 16'h0001);
                    lit("t2_ready_high", {15'h0, DATA_READY}, 16'h0001);
        toEdge(35); lit("t2_seg1", {9'h0, actSeg}, 16'h0006);
        toEdge(43); lit("t2_seg2", {9'h0, actSeg}, 16'h005B);
        toEdge(51); lit("t2_seg3", {9'h0, actSeg}, 16'h0077);
        toEdge(59); lit("t2_seg4", {9'h0, actSeg}, 16'h0071);
                    lit("t2_en4", {12'h0, actEn}, 16'h0008);

        // 3: B offered while buffer full is ignored until READY returns
        toEdge(64);
        DATA = 16'h3456; DATA_VALID = 1'b1;
        tick();
        $display("load 3456 at edge 65 ready_after=%0b", DATA_READY);
        DATA = 16'h789A;
        toEdge(96); lit("t3_fd_a", {15'h0, FRAME_DONE}, 16'h0001);
        tick();
        DATA_VALID = 1'b0;
        $display("load 789a at edge 97 ready_after=%0b", DATA_READY);
        lit("t3_ready_b", {15'h0, DATA_READY}, 16'h0000);
        toEdge(99);  lit("t3_seg_a", {9'h0, actSeg}, 16'h004F);
        toEdge(128); lit("t3_fd_b", {15'h0, FRAME_DONE}, 16'h0001);
        toEdge(131); lit("t3_seg_b", {9'h0, actSeg}, 16'h0007);

        // 5: load on the boundary clock waits a whole frame
        loadWord(16'h0BCD, 160);
        lit("t5_no_fd", {15'h0, FRAME_DONE}, 16'h0000);
        toEdge(163); lit("t5_old_seg", {9'h0, actSeg}, 16'h0007);
        toEdge(192); lit("t5_fd", {15'h0, FRAME_DONE}, 16'h0001);
        toEdge(195); lit("t5_new_seg", {9'h0, actSeg}, 16'h003F);

        // 4: leading-zero blanking
        BLANK_LZ = 1'b1;
        loadWord(16'h0030, 200);
        toEdge(227); lit("t4_en1_blank", {12'h0, actEn}, 16'h0000);
        toEdge(235); lit("t4_en2_blank", {12'h0, actEn}, 16'h0000);
        toEdge(243); lit("t4_en3", {12'h0, actEn}, 16'h0004);
                     lit("t4_seg3", {9'h0, actSeg}, 16'h004F);
        toEdge(251); lit("t4_seg4", {9'h0, actSeg}, 16'h003F);
        loadWord(16'h0000, 257);
        toEdge(291); lit("t4z_en1", {12'h0, actEn}, 16'h0000);
        toEdge(299); lit("t4z_en2", {12'h0, actEn}, 16'h0000);
        toEdge(307); lit("t4z_en3", {12'h0, actEn}, 16'h0000);
        toEdge(315); lit("t4z_en4", {12'h0, actEn}, 16'h0008);
                     lit("t4z_seg4", {9'h0, actSeg}, 16'h003F);
        BLANK_LZ = 1'b0;

        // 6: async reset mid-SHOW drops pins and the buffered value
        loadWord(16'hFFFF, 321);
        loadWord(16'h1111, 356);
        toEdge(357); lit("t6_pre_en", {12'h0, actEn}, 16'h0001);
                     lit("t6_pre_seg", {9'h0, actSeg}, 16'h0071);
        #2 RST_N = 1'b0;
        #1;
        lit("t6_async_en", {12'h0, actEn}, 16'h0000);
        lit("t6_async_seg", {9'h0, actSeg}, 16'h0000);
        lit("t6_async_ready", {15'h0, DATA_READY}, 16'h0001);
        repeat (3) tick();
        RST_N = 1'b1;
        toEdge(3);  lit("t6_post_seg", {9'h0, actSeg}, 16'h003F);
                    lit("t6_post_ready", {15'h0, DATA_READY}, 16'h0001);
        toEdge(35); lit("t6_pend_lost", {9'h0, actSeg}, 16'h003F);
        toEdge(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
